mem_lsu: RTL and testbench



---
 rtl/mem_lsu.sv | 134 +++++++++++++
 tb/tb_mem_lsu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - RV32I MEM-stage load/store unit: byte-lane data memory, LED/HEX/SW I/O window
// Load data and misalign flag are registered into the WB cycle; stores commit at the end of MEM.
module mem_lsu #(
  parameter int DMEM_ADDR_W = 13
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_lsu_vld,
  input  logic        i_lsu_wren,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_ld_data,
  output logic        o_misalign,
  output logic [31:0] o_io_ledr,
  output logic [31:0] o_io_ledg,
  output logic [31:0] o_io_hex_lo,
  output logic [31:0] o_io_hex_hi
);

  localparam int WORDS = 2 ** (DMEM_ADDR_W - 2);

  logic [31:0] dmem_q [WORDS];
  logic [31:0] ld_data_q, ld_data_d;
  logic        misalign_q, misalign_d;
  logic [31:0] ledr_q, ledg_q, hex_lo_q, hex_hi_q;
  logic [31:0] sw_meta_q, sw_sync_q;

  logic [1:0]             lane;
  logic [19:0]            page;
  logic [DMEM_ADDR_W-3:0] widx;
  logic sel_dmem, sel_ledr, sel_ledg, sel_hex_lo, sel_hex_hi, sel_sw;
  logic code_ok, misaligned, go, we;
  logic [3:0]  be;
  logic [31:0] bmask, wdata, rd_word, shifted, ext;

  assign lane = i_lsu_addr[1:0];
  assign page = i_lsu_addr[31:12];
  assign widx = i_lsu_addr[DMEM_ADDR_W-1:2];

  always_comb begin
    sel_dmem   = (i_lsu_addr[31:DMEM_ADDR_W] == '0);
    sel_ledr   = (page == 20'h10000);
    sel_ledg   = (page == 20'h10001);
    sel_hex_lo = (page == 20'h10002);
    sel_hex_hi = (page == 20'h10003);
    sel_sw     = (page == 20'h10010);

    if (i_lsu_wren)
      code_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010);
    else
      code_ok = (i_funct3 == 3'b000) || (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                (i_funct3 == 3'b100) || (i_funct3 == 3'b101);

    misaligned = ((i_funct3[1:0] == 2'b01) && lane[0]) ||
                 ((i_funct3[1:0] == 2'b10) && (lane != 2'b00));
    go = i_lsu_vld && code_ok && !misaligned;
    // Reset suppresses every write, including one presented in the same cycle.
    we = go && i_lsu_wren && !i_rst;

    case (i_funct3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    bmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

    case (i_funct3[1:0])
      2'b00:   wdata = {4{i_st_data[7:0]}};
      2'b01:   wdata = {2{i_st_data[15:0]}};
      default: wdata = i_st_data;
    endcase

    rd_word = '0;
    if (sel_dmem)        rd_word = dmem_q[widx];
    else if (sel_ledr)   rd_word = ledr_q;
    else if (sel_ledg)   rd_word = ledg_q;
    else if (sel_hex_lo) rd_word = hex_lo_q;
    else if (sel_hex_hi) rd_word = hex_hi_q;
    else if (sel_sw)     rd_word = sw_sync_q;

    shifted = rd_word >> {lane, 3'b000};
    case (i_funct3)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  ext = shifted;
      3'b100:  ext = {24'h0, shifted[7:0]};
      3'b101:  ext = {16'h0, shifted[15:0]};
      default: ext = '0;
    endcase

    ld_data_d  = (go && !i_lsu_wren) ? ext : 32'h0;
    misalign_d = i_lsu_vld && code_ok && misaligned;
  end

  // Data memory has no reset; its contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (we && sel_dmem) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) dmem_q[widx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ld_data_q  <= '0;
      misalign_q <= 1'b0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_lo_q   <= '0;
      hex_hi_q   <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
    end else begin
      ld_data_q  <= ld_data_d;
      misalign_q <= misalign_d;
      sw_meta_q  <= i_io_sw;
      sw_sync_q  <= sw_meta_q;
      if (we && sel_ledr)   ledr_q   <= (ledr_q   & ~bmask) | (wdata & bmask);
      if (we && sel_ledg)   ledg_q   <= (ledg_q   & ~bmask) | (wdata & bmask);
      if (we && sel_hex_lo) hex_lo_q <= (hex_lo_q & ~bmask) | (wdata & bmask);
      if (we && sel_hex_hi) hex_hi_q <= (hex_hi_q & ~bmask) | (wdata & bmask);
    end
  end

  assign o_ld_data   = ld_data_q;
  assign o_misalign  = misalign_q;
  assign o_io_ledr   = ledr_q;
  assign o_io_ledg   = ledg_q;
  assign o_io_hex_lo = hex_lo_q;
  assign o_io_hex_hi = hex_hi_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - directed self-checking bench for mem_lsu
module tb_mem_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_lsu_vld;
  logic        i_lsu_wren;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic [2:0]  i_funct3;
  logic [31:0] i_io_sw;
  logic [31:0] o_ld_data;
  logic        o_misalign;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;
  logic [31:0] o_io_hex_lo;
  logic [31:0] o_io_hex_hi;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  mem_lsu #(.DMEM_ADDR_W(13)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_lsu_vld(i_lsu_vld), .i_lsu_wren(i_lsu_wren),
    .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data), .i_funct3(i_funct3), .i_io_sw(i_io_sw),
    .o_ld_data(o_ld_data), .o_misalign(o_misalign), .o_io_ledr(o_io_ledr),
    .o_io_ledg(o_io_ledg), .o_io_hex_lo(o_io_hex_lo), .o_io_hex_hi(o_io_hex_hi)
  );

  always #5 i_clk = ~i_clk;

  // Presents one MEM-cycle request, then returns 1 time unit after the sampling edge.
  task automatic acc(input logic vld, input logic wren, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] data);
    i_lsu_vld  = vld;
    i_lsu_wren = wren;
    i_funct3   = f3;
    i_lsu_addr = addr;
    i_st_data  = data;
    @(posedge i_clk);
    #1;
    i_lsu_vld = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    acc(1'b1, 1'b1, F_W, 32'h1000_0000, 32'h0000_00FF);
    n_vec++;
    if (o_io_ledr !== 32'h0) begin n_err++; $display("FAIL reset_ledr got %h want %h", o_io_ledr, 32'h0); end
    n_vec++;
    if (o_io_ledg !== 32'h0 || o_io_hex_lo !== 32'h0 || o_io_hex_hi !== 32'h0) begin
      n_err++; $display("FAIL reset_io got %h %h %h want 0", o_io_ledg, o_io_hex_lo, o_io_hex_hi);
    end
    n_vec++;
    if (o_ld_data !== 32'h0 || o_misalign !== 1'b0) begin
      n_err++; $display("FAIL reset_ld got %h mis %b want 0 0", o_ld_data, o_misalign);
    end
    acc(1'b1, 1'b1, F_W, 32'h1000_0000, 32'h0000_00FF);
    n_vec++;
    if (o_io_ledr !== 32'h0) begin n_err++; $display("FAIL reset_hold_ledr got %h want %h", o_io_ledr, 32'h0); end
    // First edge with reset low services the presented store.
    i_rst = 1'b0;
    acc(1'b1, 1'b1, F_W, 32'h1000_0000, 32'h0000_0001);
    n_vec++;
    if (o_io_ledr !== 32'h1) begin n_err++; $display("FAIL reset_release_ledr got %h want %h", o_io_ledr, 32'h1); end
    acc(1'b1, 1'b1, F_W, 32'h1000_0000, 32'h0);
  endtask

  task automatic test_loads;
    logic [2:0]  f3s [5] = '{F_W, F_B, F_BU, F_H, F_HU};
    logic [31:0] ads [5] = '{32'h100, 32'h103, 32'h103, 32'h102, 32'h100};
    logic [31:0] exp [5] = '{32'hDEADBEEF, 32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    acc(1'b1, 1'b1, F_W, 32'h100, 32'hDEADBEEF);
    n_vec++;
    if (o_ld_data !== 32'h0) begin n_err++; $display("FAIL store_ld_zero got %h want %h", o_ld_data, 32'h0); end
    for (int k = 0; k < 5; k++) begin
      acc(1'b1, 1'b0, f3s[k], ads[k], 32'h0);
      n_vec++;
      if (o_ld_data !== exp[k] || o_misalign !== 1'b0) begin
        n_err++; $display("FAIL load_%0d got %h mis %b want %h mis 0", k, o_ld_data, o_misalign, exp[k]);
      end
    end
    acc(1'b1, 1'b0, F_B, 32'h100, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'hFFFFFFEF) begin n_err++; $display("FAIL load_lb0 got %h want %h", o_ld_data, 32'hFFFFFFEF); end
  endtask

  task automatic test_store_merge;
    acc(1'b1, 1'b1, F_W, 32'h200, 32'h11223344);
    acc(1'b1, 1'b1, F_B, 32'h201, 32'h000000AA);
    acc(1'b1, 1'b1, F_H, 32'h202, 32'h00005566);
    acc(1'b1, 1'b0, F_W, 32'h200, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h5566AA44) begin n_err++; $display("FAIL merge_word got %h want %h", o_ld_data, 32'h5566AA44); end
    acc(1'b1, 1'b1, F_H, 32'h200, 32'hFFFF0077);
    acc(1'b1, 1'b0, F_W, 32'h200, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h55660077) begin n_err++; $display("FAIL merge_sh_lo got %h want %h", o_ld_data, 32'h55660077); end
    acc(1'b1, 1'b1, F_W, 32'h204, 32'hCAFEF00D);
    acc(1'b1, 1'b0, F_W, 32'h204, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'hCAFEF00D) begin n_err++; $display("FAIL back_to_back got %h want %h", o_ld_data, 32'hCAFEF00D); end
    acc(1'b1, 1'b1, F_W, 32'h1FFC, 32'h0BADCAFE);
    acc(1'b1, 1'b0, F_W, 32'h1FFC, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h0BADCAFE) begin n_err++; $display("FAIL dmem_top got %h want %h", o_ld_data, 32'h0BADCAFE); end
  endtask

  task automatic test_misalign;
    acc(1'b1, 1'b0, F_H, 32'h101, 32'h0);
    n_vec++;
    if (o_misalign !== 1'b1 || o_ld_data !== 32'h0) begin
      n_err++; $display("FAIL misalign_lh got mis %b ld %h want 1 0", o_misalign, o_ld_data);
    end
    acc(1'b0, 1'b0, F_W, 32'h0, 32'h0);
    n_vec++;
    if (o_misalign !== 1'b0) begin n_err++; $display("FAIL misalign_pulse got %b want 0", o_misalign); end
    acc(1'b1, 1'b1, F_W, 32'h102, 32'h12345678);
    n_vec++;
    if (o_misalign !== 1'b1) begin n_err++; $display("FAIL misalign_sw got %b want 1", o_misalign); end
    acc(1'b1, 1'b0, F_W, 32'h100, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'hDEADBEEF || o_misalign !== 1'b0) begin
      n_err++; $display("FAIL misalign_dropped got %h mis %b want deadbeef 0", o_ld_data, o_misalign);
    end
    acc(1'b1, 1'b0, F_W, 32'h102, 32'h0);
    n_vec++;
    if (o_misalign !== 1'b1 || o_ld_data !== 32'h0) begin
      n_err++; $display("FAIL misalign_lw got mis %b ld %h want 1 0", o_misalign, o_ld_data);
    end
  endtask

  task automatic test_io;
    acc(1'b1, 1'b1, F_W, 32'h1000_0000, 32'h0000_00FF);
    n_vec++;
    if (o_io_ledr !== 32'hFF) begin n_err++; $display("FAIL io_ledr got %h want %h", o_io_ledr, 32'hFF); end
    acc(1'b1, 1'b1, F_B, 32'h1000_2001, 32'h0000_003F);
    n_vec++;
    if (o_io_hex_lo !== 32'h00003F00) begin n_err++; $display("FAIL io_hex_lo got %h want %h", o_io_hex_lo, 32'h3F00); end
    acc(1'b1, 1'b1, F_B, 32'h1000_0002, 32'h0000_00AB);
    n_vec++;
    if (o_io_ledr !== 32'h00AB00FF) begin n_err++; $display("FAIL io_ledr_sb got %h want %h", o_io_ledr, 32'h00AB00FF); end
    acc(1'b1, 1'b1, F_W, 32'h1000_1004, 32'h12345678);
    n_vec++;
    if (o_io_ledg !== 32'h12345678) begin n_err++; $display("FAIL io_ledg_alias got %h want %h", o_io_ledg, 32'h12345678); end
    acc(1'b1, 1'b1, F_H, 32'h1000_3002, 32'h0000BEEF);
    n_vec++;
    if (o_io_hex_hi !== 32'hBEEF0000) begin n_err++; $display("FAIL io_hex_hi got %h want %h", o_io_hex_hi, 32'hBEEF0000); end
    acc(1'b1, 1'b1, F_W, 32'h1001_0000, 32'hFFFFFFFF);
    acc(1'b1, 1'b0, F_W, 32'h1001_0000, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h0 || o_io_ledr !== 32'h00AB00FF || o_io_ledg !== 32'h12345678) begin
      n_err++; $display("FAIL io_sw_store got ld %h ledr %h ledg %h want 0 00ab00ff 12345678", o_ld_data, o_io_ledr, o_io_ledg);
    end
    acc(1'b1, 1'b0, F_BU, 32'h1000_0002, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h000000AB) begin n_err++; $display("FAIL io_ledr_lbu got %h want %h", o_ld_data, 32'hAB); end
    i_io_sw = 32'h0000_1234;
    acc(1'b0, 1'b0, F_W, 32'h0, 32'h0);
    acc(1'b0, 1'b0, F_W, 32'h0, 32'h0);
    acc(1'b1, 1'b0, F_W, 32'h1001_0000, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h00001234) begin n_err++; $display("FAIL io_sw_sync got %h want %h", o_ld_data, 32'h1234); end
  endtask

  task automatic test_unmapped_and_invalid;
    acc(1'b1, 1'b0, F_W, 32'h3000_0000, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h0) begin n_err++; $display("FAIL unmapped_ld got %h want %h", o_ld_data, 32'h0); end
    acc(1'b1, 1'b0, F_W, 32'h100, 32'h0);
    acc(1'b0, 1'b0, F_W, 32'h100, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h0) begin n_err++; $display("FAIL novld_ld got %h want %h", o_ld_data, 32'h0); end
    acc(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'h0 || o_misalign !== 1'b0) begin
      n_err++; $display("FAIL bad_f3_ld got %h mis %b want 0 0", o_ld_data, o_misalign);
    end
    acc(1'b1, 1'b1, 3'b100, 32'h100, 32'h0);
    acc(1'b1, 1'b0, F_W, 32'h100, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL bad_f3_st got %h want %h", o_ld_data, 32'hDEADBEEF); end
    acc(1'b1, 1'b0, 3'b110, 32'h101, 32'h0);
    n_vec++;
    if (o_misalign !== 1'b0) begin n_err++; $display("FAIL bad_f3_nomis got %b want 0", o_misalign); end
    i_rst = 1'b1;
    acc(1'b1, 1'b1, F_W, 32'h100, 32'h55555555);
    i_rst = 1'b0;
    acc(1'b1, 1'b0, F_W, 32'h100, 32'h0);
    n_vec++;
    if (o_ld_data !== 32'hDEADBEEF || o_io_ledr !== 32'h0) begin
      n_err++; $display("FAIL reset_keeps_dmem got %h ledr %h want deadbeef 0", o_ld_data, o_io_ledr);
    end
  endtask

  initial begin
    i_rst = 1'b1; i_lsu_vld = 1'b0; i_lsu_wren = 1'b0; i_lsu_addr = '0;
    i_st_data = '0; i_funct3 = '0; i_io_sw = '0;
    #2;
    test_reset;
    test_loads;
    test_store_merge;
    test_misalign;
    test_io;
    test_unmapped_and_invalid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
